mult_lut_arbiter: RTL and testbench
===================================

# mult_lut_arbiter

Round-robin arbiter and sequencer that shares one `MultiplierLUT` 2-bit × 2-bit multiplier instance among `NREQ` requesters. Each requester presents operands over a valid/ready handshake. One request is granted per cycle and driven into the shared multiplier. The product is captured in a single-entry output register that carries the winner's ID back to the consumer.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `IDW`, default 2: width of the requester ID, equal to clog2(NREQ).
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NREQ: per-requester request valid.
- `req_a` in 2*NREQ: operand a; requester i uses bits [2i+1:2i].
- `req_b` in 2*NREQ: operand b, packed the same way as `req_a`.
- `req_ready` out NREQ: per-requester accept; one-hot or zero.
- `resp_valid` out 1: output register holds a result.
- `resp_ready` in 1: consumer accepts the result.
- `resp_z` out 4: registered product a*b.
- `resp_id` out IDW: index of the requester that produced `resp_z`.

## Operation
- **Output state machine** (the output valid bit): EMPTY or FULL.
  - EMPTY→FULL on accept.
  - FULL→FULL on accept with `resp_ready`; the result is replaced back-to-back.
  - FULL→EMPTY on `resp_ready` with no accept.
  - FULL holds while `resp_ready` is 0.
- **Slot free**: `slot_free = !resp_valid || resp_ready`.
- **Round-robin pointer** `ptr` (IDW bits): the winner is the first i with `req_valid[i]`, searching from `ptr` upward and wrapping modulo NREQ.
- **Ready**: `req_ready[winner] = slot_free`, combinational. All other `req_ready` bits are 0. If there is no valid request, `req_ready` is 0.
- **Accept**: `req_valid[i] && req_ready[i]`.
  - The winner's operands are muxed onto the `MultiplierLUT` `a`/`b` ports.
  - `z` is registered into `resp_z` and the winner index into `resp_id`.
  - `ptr` becomes winner+1 (mod NREQ).
- **No accept**: `ptr` holds. A blocked output does not rotate priority.
- **Arithmetic**: 2×2 unsigned to 4 bits; maximum product is 3*3 = 9, so there is no overflow.
- **Requester rules**:
  - A requester must hold `req_valid` and its operands stable until accepted.
  - Dropping `req_valid` before accept is allowed; that request is simply never served.
- **Reset values**: `resp_valid` = 0, `resp_z` = 0, `resp_id` = 0, `ptr` = 0, all grant counters = 0.
  - `req_ready` is 0 during reset regardless of `req_valid`.
  - Reset mid-operation discards a held result without handshake; the pending request is re-arbitrated from `ptr` = 0 after reset.

## Timing
- Accept in cycle N gives `resp_valid` = 1 with the product in cycle N+1 (1-cycle latency).
- Sustained throughput is 1 result per cycle while `resp_ready` = 1.
- The combinational path is `resp_ready` → `req_ready`. No path exists from `req_valid` of requester i to `req_ready` of a requester ahead of i in the search order.
- With `resp_ready` = 0 and FULL, every `req_ready` = 0 and `resp_z`/`resp_id` are held.
- Simultaneous `resp_ready` and accept in the same cycle replaces the result with no bubble.

## Configuration
- `MULT_ARB_GNT_CNT_EN` defined:
  - Adds output `gnt_cnt` (8*NREQ bits): one 8-bit counter per requester.
  - Each counter increments on that requester's accept and saturates at 255.
  - Counters clear on `rst`.
- Undefined: the port and counters are absent, and arbitration behaviour is identical.

## Test plan
- **Reset**: `rst`=1 for 2 cycles with all `req_valid`=1. Required: `req_ready`=0, `resp_valid`=0, `resp_z`=0 throughout. First grant after release goes to requester 0.
- **Single requester**: requester 2 with a=3, b=3 and `resp_ready`=1. Required: accept in cycle N; in N+1 `resp_z`=9, `resp_id`=2, `resp_valid`=1.
- **Fairness**: all 4 valid with a=i, b=2 and `resp_ready`=1. Required: grants 0,1,2,3,0… one per cycle; `resp_z` sequence 0,2,4,6.
- **Backpressure**: requester 1 (a=2, b=3) accepted, then `resp_ready`=0 for 3 cycles. Required: `resp_z`=6 held, `req_ready`=0, `ptr` unchanged. On `resp_ready`=1, the next winner is requester 2 if valid.
- **Exhaustive**: random 1000 requests on all ports with random `resp_ready`. Required: every result equals `req_a`*`req_b` of the ID'd requester; zero mismatches against a reference model.
- **Counters** (with `MULT_ARB_GNT_CNT_EN`): requester 0 is the only valid requester for 300 accepts. Required: `gnt_cnt[7:0]`=255 and all other counters = 0.

Source files
------------

// File: rtl/mult_lut_arbiter.sv
// mult_lut_arbiter
//   Round-robin arbiter that shares one MultiplierLUT (2-bit x 2-bit unsigned)
//   among NREQ requesters. One request is granted per cycle. Its product is
//   captured with the winner's ID in a single-entry output register that is
//   drained over a valid/ready handshake.
//
// Parameters
//   NREQ  number of requesters (2..8)
//   IDW   requester ID width, clog2(NREQ)
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   req_valid    per-requester request valid
//   req_a/req_b  packed operands, requester i on bits [2i+1:2i]
//   req_ready    per-requester accept (one-hot or zero)
//   resp_valid   output register holds a result
//   resp_ready   consumer takes the result
//   resp_z       registered product
//   resp_id      requester that produced resp_z
//   gnt_cnt      per-requester saturating 8-bit grant counters
//                (present only when MULT_ARB_GNT_CNT_EN is defined)

module MultiplierLUT (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] z
);
    always_comb begin
        z = 4'd0;
        case ({a, b})
            4'b00_00: z = 4'd0;
            4'b00_01: z = 4'd0;
            4'b00_10: z = 4'd0;
            4'b00_11: z = 4'd0;
            4'b01_00: z = 4'd0;
            4'b01_01: z = 4'd1;
            4'b01_10: z = 4'd2;
            4'b01_11: z = 4'd3;
            4'b10_00: z = 4'd0;
            4'b10_01: z = 4'd2;
            4'b10_10: z = 4'd4;
            4'b10_11: z = 4'd6;
            4'b11_00: z = 4'd0;
            4'b11_01: z = 4'd3;
            4'b11_10: z = 4'd6;
            4'b11_11: z = 4'd9;
            default:  z = 4'd0;
        endcase
    end
endmodule

module mult_lut_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [2*NREQ-1:0] req_a,
    input  logic [2*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [3:0]        resp_z,
    output logic [IDW-1:0]    resp_id
`ifdef MULT_ARB_GNT_CNT_EN
    ,
    output logic [8*NREQ-1:0] gnt_cnt
`endif
);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] rot_p0;
    logic [IDW-1:0]  off_p0;
    logic [IDW:0]    sum_p0;
    logic [IDW-1:0]  win_p0;
    logic            found_p0;
    logic            slot_free;
    logic            accept_p0;
    logic [1:0]      mul_a_p0;
    logic [1:0]      mul_b_p0;
    logic [3:0]      mul_z_p0;
    logic            vld_p1;
    logic [3:0]      z_p1;
    logic [IDW-1:0]  id_p1;

    // ---- stage p0: arbitration, operand mux, shared multiplier ----
    // Rotating the valid vector so bit 0 is requester ptr turns the
    // wrap-around search into a plain lowest-set-bit priority pick; a valid
    // bit only influences requesters later in the search order.
    always_comb begin
        rot_p0   = NREQ'({req_valid, req_valid} >> ptr);
        found_p0 = 1'b0;
        off_p0   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found_p0 && rot_p0[k]) begin
                found_p0 = 1'b1;
                off_p0   = IDW'(k);
            end
        end
        sum_p0 = {1'b0, ptr} + {1'b0, off_p0};
        win_p0 = (sum_p0 >= (IDW+1)'(NREQ)) ? IDW'(sum_p0 - (IDW+1)'(NREQ))
                                             : IDW'(sum_p0);
    end

    assign slot_free = !vld_p1 || resp_ready;
    assign accept_p0 = found_p0 && slot_free && !rst;

    always_comb begin
        req_ready = '0;
        mul_a_p0  = 2'd0;
        mul_b_p0  = 2'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_p0 == IDW'(i)) begin
                req_ready[i] = accept_p0;
                mul_a_p0     = req_a[2*i +: 2];
                mul_b_p0     = req_b[2*i +: 2];
            end
        end
    end

    MultiplierLUT u_mult (
        .a (mul_a_p0),
        .b (mul_b_p0),
        .z (mul_z_p0)
    );

    // ---- stage p1: single-entry output register and priority pointer ----
    // A blocked output leaves ptr alone so backpressure never rotates priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            z_p1   <= '0;
            id_p1  <= '0;
            ptr    <= '0;
        end else if (accept_p0) begin
            vld_p1 <= 1'b1;
            z_p1   <= mul_z_p0;
            id_p1  <= win_p0;
            ptr    <= (win_p0 == IDW'(NREQ-1)) ? '0 : win_p0 + 1'b1;
        end else if (resp_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign resp_valid = vld_p1;
    assign resp_z     = z_p1;
    assign resp_id    = id_p1;

`ifdef MULT_ARB_GNT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_cnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (accept_p0 && win_p0 == IDW'(i)) begin
                    gnt_cnt[8*i +: 8] <= sat_inc8(gnt_cnt[8*i +: 8]);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_mult_lut_arbiter.sv
module tb_mult_lut_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [2*NREQ-1:0] req_a;
    logic [2*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              resp_valid;
    logic              resp_ready;
    logic [3:0]        resp_z;
    logic [IDW-1:0]    resp_id;
`ifdef MULT_ARB_GNT_CNT_EN
    logic [8*NREQ-1:0] gnt_cnt;
`endif

    mult_lut_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_z     (resp_z),
        .resp_id    (resp_id)
`ifdef MULT_ARB_GNT_CNT_EN
        ,
        .gnt_cnt    (gnt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state: output slot contents and round-robin start point
    bit              m_valid = 1'b0;
    int              m_z     = 0;
    int              m_id    = 0;
    int              m_ptr   = 0;
    int              n_acc   = 0;
    logic [NREQ-1:0] last_ready;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clock cycle: inputs are already driven; check the combinational
    // grant before the edge, advance the model at the edge, check outputs after.
    task automatic tick();
        int              w;
        int              idx;
        int              pa;
        int              pb;
        bit              acc;
        logic [NREQ-1:0] exp_ready;
        #1;
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (w < 0 && ((req_valid >> idx) & 1) != 0) w = idx;
        end
        exp_ready = '0;
        if (!rst && w >= 0 && (!m_valid || resp_ready)) exp_ready = NREQ'(1) << w;
        last_ready = req_ready;
        chk("req_ready", req_ready, exp_ready);
        acc = (exp_ready != 0);
        pa = 0;
        pb = 0;
        if (acc) begin
            pa = int'((req_a >> (2 * w)) & 3);
            pb = int'((req_b >> (2 * w)) & 3);
        end
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_z     = 0;
            m_id    = 0;
            m_ptr   = 0;
        end else if (acc) begin
            m_valid = 1'b1;
            m_z     = pa * pb;
            m_id    = w;
            m_ptr   = (w + 1) % NREQ;
            n_acc++;
        end else if (resp_ready) begin
            m_valid = 1'b0;
        end
        #1;
        chk("resp_valid", resp_valid, m_valid);
        chk("resp_z", resp_z, m_z);
        chk("resp_id", resp_id, m_id);
    endtask

    initial begin
        int acc_start;
        int cycles;
        rst        = 1'b1;
        req_valid  = '1;
        req_a      = {2'd3, 2'd2, 2'd1, 2'd0};
        req_b      = {2'd1, 2'd1, 2'd1, 2'd1};
        resp_ready = 1'b1;

        // reset with every requester asking
        for (int r = 0; r < 2; r++) begin
            tick();
            chk("rst_ready", last_ready, 0);
            chk("rst_valid", resp_valid, 0);
            chk("rst_z", resp_z, 0);
        end
        rst = 1'b0;
        tick();
        chk("first_grant", last_ready, 4'b0001);

        // single requester 2 with 3*3
        req_valid = 4'b0100;
        req_a     = '1;
        req_b     = '1;
        tick();
        chk("single_ready", last_ready, 4'b0100);
        chk("single_valid", resp_valid, 1);
        chk("single_z", resp_z, 9);
        chk("single_id", resp_id, 2);

        // fairness from a fresh pointer
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        req_valid = '1;
        req_a     = {2'd3, 2'd2, 2'd1, 2'd0};
        req_b     = {2'd2, 2'd2, 2'd2, 2'd2};
        for (int r = 0; r < 5; r++) begin
            tick();
            chk("fair_id", resp_id, r % 4);
            chk("fair_z", resp_z, 2 * (r % 4));
        end

        // backpressure: requester 1 gets 2*3, then the consumer stalls
        req_valid = 4'b0010;
        req_a     = {2'd1, 2'd1, 2'd2, 2'd1};
        req_b     = {2'd1, 2'd1, 2'd3, 2'd1};
        tick();
        chk("bp_z", resp_z, 6);
        chk("bp_id", resp_id, 1);
        resp_ready = 1'b0;
        req_valid  = 4'b1101;
        for (int r = 0; r < 3; r++) begin
            tick();
            chk("bp_stall_ready", last_ready, 0);
            chk("bp_hold_valid", resp_valid, 1);
            chk("bp_hold_z", resp_z, 6);
            chk("bp_hold_id", resp_id, 1);
        end
        resp_ready = 1'b1;
        tick();
        chk("bp_next_ready", last_ready, 4'b0100);
        chk("bp_next_id", resp_id, 2);
        chk("bp_next_z", resp_z, 1);

        // randomized traffic obeying the hold-until-accepted rule
        acc_start = n_acc;
        cycles    = 0;
        while (n_acc - acc_start < 1000 && cycles < 20000) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || last_ready[i]) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    req_a = (req_a & ~(8'(3) << (2 * i))) | (8'($urandom_range(0, 3)) << (2 * i));
                    req_b = (req_b & ~(8'(3) << (2 * i))) | (8'($urandom_range(0, 3)) << (2 * i));
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            rst        = (cycles == 600);
            tick();
            cycles++;
        end
        rst = 1'b0;
        chk("rand_accepts", (n_acc - acc_start >= 1000) ? 1 : 0, 1);

`ifdef MULT_ARB_GNT_CNT_EN
        rst = 1'b1;
        tick();
        chk("cnt_reset", gnt_cnt, 0);
        rst        = 1'b0;
        req_valid  = 4'b0001;
        resp_ready = 1'b1;
        for (int r = 0; r < 300; r++) tick();
        chk("cnt_sat0", gnt_cnt[7:0], 255);
        chk("cnt_others", gnt_cnt[31:8], 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
